evm_display_three_candidates: RTL and testbench



---
 rtl/evm_pkg.sv | 54 +++++
 rtl/evm_seg_driver.sv | 79 +++++++
 rtl/evm_display_three_candidates.sv | 108 ++++++++++
 tb/tb_evm_display_three_candidates.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and seven-segment constants for the three-candidate voting core.
package evm_pkg;

    localparam int unsigned NUM_CAND = 3;
    localparam int unsigned CAND_A   = 0;
    localparam int unsigned CAND_B   = 1;
    localparam int unsigned CAND_C   = 2;

    typedef logic [3:0] vote_cnt_t;

    typedef enum logic [2:0] {
        LeadNone,
        LeadA,
        LeadB,
        LeadC,
        LeadTie
    } leader_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_digit(input vote_cnt_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/evm_seg_driver.sv
// Multiplexed 4-digit seven-segment scan: counts on digits 0-2, leader on digit 3.
// Digit 3 shows the leader only when WINNER_DIGIT_EN is defined; otherwise it is blank.
module evm_seg_driver
    import evm_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic      clk,
    input  logic      rst,
    input  vote_cnt_t count_a,
    input  vote_cnt_t count_b,
    input  vote_cnt_t count_c,
    input  leader_t   leader,
    output logic [6:0] display,
    output logic [3:0] an
);

    logic [REFRESH_BITS-1:0] scan_q;
    logic [1:0]              sel;
    logic [6:0]              digit3;
    logic [6:0]              seg_d;
    logic [3:0]              an_d;

    assign sel = scan_q[REFRESH_BITS-1 -: 2];

`ifdef WINNER_DIGIT_EN
    always_comb begin
        digit3 = SEG_BLANK;
        case (leader)
            LeadA:   digit3 = SEG_A;
            LeadB:   digit3 = SEG_B;
            LeadC:   digit3 = SEG_C;
            LeadTie: digit3 = SEG_DASH;
            default: digit3 = SEG_BLANK;
        endcase
    end
`else
    logic unused_leader;
    assign unused_leader = ^leader;
    assign digit3        = SEG_BLANK;
`endif

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        case (sel)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_digit(count_a);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = seg_digit(count_b);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = seg_digit(count_c);
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = digit3;
            end
        endcase
    end

    // Anode and pattern share one register stage so they never disagree for a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            an      <= 4'b1111;
            display <= SEG_BLANK;
        end else begin
            scan_q  <= scan_q + 1'b1;
            an      <= an_d;
            display <= seg_d;
        end
    end

endmodule

// File: rtl/evm_display_three_candidates.sv
// Three-candidate voting machine: button conditioning, lockout, saturating counts,
// leader LEDs and display scan. Optional leader digit under WINNER_DIGIT_EN.
module evm_display_three_candidates
    import evm_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = 50000,
    parameter int unsigned REFRESH_BITS   = 18,
    parameter int unsigned MAX_VOTES      = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vote_enable,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [6:0] display,
    output logic [3:0] an,
    output logic       ledA,
    output logic       ledB,
    output logic       ledC
);

    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [2:0]        sync1_q;
    logic [2:0]        sync2_q;
    logic [2:0]        prev_q;
    logic [2:0]        edges;
    logic              single_edge;
    logic              accept;
    logic [LOCK_W-1:0] lock_q;
    vote_cnt_t         votes [0:NUM_CAND-1];
    leader_t           leader;

    assign edges       = sync2_q & ~prev_q;
    assign single_edge = (edges == 3'b001) || (edges == 3'b010) || (edges == 3'b100);
    assign accept      = vote_enable && (lock_q == '0) && single_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {C, B, A};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Rejected edges (multi-press, disabled, locked) never touch the lockout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
        end else if (accept) begin
            lock_q <= LOCK_W'(LOCKOUT_CYCLES - 1);
        end else if (lock_q != '0) begin
            lock_q <= lock_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                votes[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                if (accept && edges[i] && (votes[i] < vote_cnt_t'(MAX_VOTES))) begin
                    votes[i] <= votes[i] + 4'd1;
                end
            end
        end
    end

    assign ledA = (votes[CAND_A] != '0) && (votes[CAND_A] >= votes[CAND_B])
                  && (votes[CAND_A] >= votes[CAND_C]);
    assign ledB = (votes[CAND_B] != '0) && (votes[CAND_B] >= votes[CAND_A])
                  && (votes[CAND_B] >= votes[CAND_C]);
    assign ledC = (votes[CAND_C] != '0) && (votes[CAND_C] >= votes[CAND_A])
                  && (votes[CAND_C] >= votes[CAND_B]);

    // No LED lit only happens when every count is zero
    always_comb begin
        leader = LeadTie;
        case ({ledC, ledB, ledA})
            3'b000:  leader = LeadNone;
            3'b001:  leader = LeadA;
            3'b010:  leader = LeadB;
            3'b100:  leader = LeadC;
            default: leader = LeadTie;
        endcase
    end

    evm_seg_driver #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_seg_driver (
        .clk    (clk),
        .rst    (rst),
        .count_a(votes[CAND_A]),
        .count_b(votes[CAND_B]),
        .count_c(votes[CAND_C]),
        .leader (leader),
        .display(display),
        .an     (an)
    );

endmodule

// File: tb/tb_evm_display_three_candidates.sv
// Directed plus randomized bench for the voting core against an event-level vote model.
module tb_evm_display_three_candidates;

    localparam int unsigned LOCK = 40;
    localparam int unsigned RB   = 6;
    localparam int unsigned MAXV = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       vote_enable;
    logic       A;
    logic       B;
    logic       C;
    logic [6:0] display;
    logic [3:0] an;
    logic       ledA;
    logic       ledB;
    logic       ledC;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mv [3];
    int last_acc;
    logic [6:0] seg_tab [0:9];

    evm_display_three_candidates #(
        .LOCKOUT_CYCLES(LOCK),
        .REFRESH_BITS  (RB),
        .MAX_VOTES     (MAXV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vote_enable(vote_enable),
        .A          (A),
        .B          (B),
        .C          (C),
        .display    (display),
        .an         (an),
        .ledA       (ledA),
        .ledB       (ledB),
        .ledC       (ledC)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Leader rule straight from the definition: nonzero and equal to the maximum
    function automatic logic [2:0] model_leds();
        int mx;
        logic [2:0] l;
        mx = mv[0];
        if (mv[1] > mx) mx = mv[1];
        if (mv[2] > mx) mx = mv[2];
        for (int i = 0; i < 3; i++) l[i] = (mv[i] > 0) && (mv[i] == mx);
        return l;
    endfunction

    function automatic logic [6:0] model_seg(input int d);
        logic [2:0] l;
        if (d < 3) return seg_tab[mv[d]];
`ifdef WINNER_DIGIT_EN
        l = model_leds();
        case (l)
            3'b000:  return 7'b1111111;
            3'b001:  return 7'b0001000;
            3'b010:  return 7'b0000011;
            3'b100:  return 7'b1000110;
            default: return 7'b0111111;
        endcase
`else
        l = 3'b000;
        return 7'b1111111 | {4'b0000, l};
`endif
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        A           = 1'b0;
        B           = 1'b0;
        C           = 1'b0;
        vote_enable = 1'b0;
        #2;
        chk("rst_an", 8'(an), 8'(4'b1111));
        chk("rst_display", 8'(display), 8'(7'b1111111));
        chk("rst_leds", 8'({ledC, ledB, ledA}), 8'(3'b000));
        #98;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) mv[i] = 0;
        last_acc = -100000;
        @(posedge clk);
        #1;
    endtask

    // Starts one cycle after a rising edge; rise of mask happens now, next step after gap cycles
    task automatic press(input logic [2:0] mask, input int width, input int gap, input logic en);
        int pc;
        int idx;
        vote_enable = en;
        {C, B, A}   = mask;
        pc  = 0;
        idx = 0;
        for (int i = 0; i < 3; i++) if (mask[i]) begin pc++; idx = i; end
        if (en && pc == 1 && (cyc - last_acc) >= int'(LOCK)) begin
            if (mv[idx] < int'(MAXV)) mv[idx]++;
            last_acc = cyc;
        end
        repeat (width) @(posedge clk);
        #1;
        {C, B, A} = 3'b000;
        repeat (gap - width) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_votes%0d", tag, i), 8'(dut.votes[i]), 8'(mv[i]));
        end
        chk({tag, "_leds"}, 8'({ledC, ledB, ledA}), 8'(model_leds()));
    endtask

    task automatic check_display(input string tag);
        logic [3:0] exp_an;
        bit found;
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            found  = 1'b0;
            for (int k = 0; k < (8 << RB) && !found; k++) begin
                @(negedge clk);
                if (an === exp_an) found = 1'b1;
            end
            n_cmp++;
            assert (found)
            else begin
                n_err++;
                $error("FAIL %s_an%0d: observed timeout expected %b", tag, d, exp_an);
            end
            if (found) chk($sformatf("%s_dig%0d", tag, d), 8'(display), 8'(model_seg(d)));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        do_reset();
        check_counts("reset");
        check_display("reset");

        for (int i = 0; i < 5; i++) press(3'b001, 10, LOCK + 20, 1'b1);
        check_counts("five_a");
        chk("five_a_direct", 8'(dut.votes[0]), 8'd5);
        check_display("five_a");

        for (int i = 0; i < 3; i++) press(3'b010, 10, LOCK + 20, 1'b1);
        press(3'b100, 10, LOCK + 20, 1'b1);
        check_counts("abc_531");
        press(3'b001, 10, LOCK + 20, 1'b0);
        press(3'b100, 10, LOCK + 20, 1'b0);
        check_counts("disabled");
        check_display("disabled");

        press(3'b011, 2, 4, 1'b1);
        press(3'b010, 2, LOCK + 20, 1'b1);
        check_counts("simul");

        press(3'b001, 2, LOCK / 2, 1'b1);
        press(3'b001, 2, LOCK + 20, 1'b1);
        check_counts("lockout");

        press(3'b001, 2, LOCK - 1, 1'b1);
        press(3'b010, 2, LOCK + 20, 1'b1);
        check_counts("edge_minus1");
        press(3'b001, 2, LOCK, 1'b1);
        press(3'b010, 2, LOCK + 20, 1'b1);
        check_counts("edge_exact");

        for (int i = 0; i < 10; i++) press(3'b001, 3, LOCK + 20, 1'b1);
        check_counts("saturate");
        chk("saturate_direct", 8'(dut.votes[0]), 8'd9);

        do_reset();
        press(3'b001, 3, LOCK + 20, 1'b1);
        press(3'b010, 3, LOCK + 20, 1'b1);
        press(3'b001, 3, LOCK + 20, 1'b1);
        press(3'b010, 3, LOCK + 20, 1'b1);
        check_counts("tie");
        chk("tie_direct", 8'({ledC, ledB, ledA}), 8'(3'b011));
        check_display("tie");

        for (int n = 0; n < 60; n++) begin
            logic [2:0] mask;
            int width;
            int gap;
            int r;
            mask = 3'($urandom_range(1, 7));
            if ($urandom % 4 != 0) mask = 3'(1 << $urandom_range(0, 2));
            width = $urandom_range(2, 4);
            r = $urandom % 4;
            case (r)
                0:       gap = $urandom_range(6, LOCK - 2);
                1:       gap = LOCK - 1;
                2:       gap = LOCK;
                default: gap = $urandom_range(LOCK + 1, LOCK + 30);
            endcase
            press(mask, width, gap, ($urandom % 5) != 0);
            check_counts($sformatf("rnd%0d", n));
            if (n % 20 == 19) check_display($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
